// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the multu_hilo multiplier: read-select encoding
// (matches the ALU control Sel field) and the multiply FSM state type.
package multu_hilo_pkg;

   // Read-select encoding for mfhi/mflo writeback
   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_HI   = 2'b01;
   localparam logic [1:0] SEL_LO   = 2'b10;

   // Multiply FSM states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } multu_state_e;

   // True when sel addresses one of the result registers
   function automatic logic sel_is_reg(input logic [1:0] sel);
      return (sel == SEL_HI) || (sel == SEL_LO);
   endfunction

endpackage : multu_hilo_pkg

// File: rtl/multu_hilo_if.sv
// Bus between ALU control / writeback and the multu_hilo multiplier.
//
// Handshake: start is a request that is accepted only on a rising edge where
// busy==0 (there is no separate ready; ready is !busy). A request seen while
// busy is dropped, not queued. done is a one-cycle pulse marking the edge on
// which hi/lo took the new product; busy is low in that cycle so a new start
// may be presented immediately. sel is a pure read-select and never affects
// state.
interface multu_hilo_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       sel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] rd_data;

   // Requester side (ALU control / writeback)
   modport master (
      output start, op_a, op_b, sel,
      input  busy, done, hi, lo, rd_data
   );

   // Multiplier side
   modport slave (
      input  start, op_a, op_b, sel,
      output busy, done, hi, lo, rd_data
   );

endinterface : multu_hilo_if

// File: rtl/multu_hilo_step.sv
// One shift-add step of the unsigned multiplier. Purely combinational:
// conditionally adds the multiplicand into the accumulator, then shifts the
// multiplicand left and the multiplier right. The 2W accumulator cannot
// overflow because the full product always fits in 2W bits.
module multu_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [2*WIDTH-1:0] i_mcand,
   input  logic [WIDTH-1:0]   i_mplier,
   output logic [2*WIDTH-1:0] o_acc,
   output logic [2*WIDTH-1:0] o_mcand,
   output logic [WIDTH-1:0]   o_mplier
);

   logic [2*WIDTH-1:0] w_sum;

   assign w_sum = i_acc + i_mcand;

   // Add when the current multiplier LSB is set, then advance both shifters
   always_comb begin
      o_acc    = i_mplier[0] ? w_sum : i_acc;
      o_mcand  = i_mcand << 1;
      o_mplier = i_mplier >> 1;
   end

endmodule : multu_step

// File: rtl/multu_hilo.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier with HI/LO registers.
// A start pulse in IDLE launches a multiply; HI/LO update only on the finish
// edge, together with a one-cycle done pulse. rd_data muxes HI/LO for
// mfhi/mflo writeback.
// Optional feature: define MULTU_EARLY_EXIT_EN to finish as soon as the
// shifted multiplier reaches zero (results identical, only latency shrinks).
module multu_hilo
   import multu_hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   multu_hilo_if.slave     bus,
   output multu_state_e    o_dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   // FSM
   multu_state_e r_state;
   multu_state_e w_next_state;
   logic         w_load;
   logic         w_step;
   logic         w_finish;
   logic         w_last;

   // Datapath
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic [2*WIDTH-1:0] w_next_acc;
   logic [2*WIDTH-1:0] w_next_mcand;
   logic [WIDTH-1:0]   w_next_mplier;
   logic [WIDTH-1:0]   w_rd_data;

   multu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .i_mplier (r_mplier),
      .o_acc    (w_next_acc),
      .o_mcand  (w_next_mcand),
      .o_mplier (w_next_mplier)
   );

   // Decide whether the current RUN edge is the last one
   always_comb begin
`ifdef MULTU_EARLY_EXIT_EN
      w_last = (r_cnt == LAST_CNT) || (w_next_mplier == '0);
`else
      w_last = (r_cnt == LAST_CNT);
`endif
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state and datapath controls
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            // start is ignored here: operands are never resampled mid-run
            w_step = 1'b1;
            if (w_last) begin
               w_finish     = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Operand load and shift-add iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_load) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, bus.op_a};
         r_mplier <= bus.op_b;
         r_cnt    <= '0;
      end else if (w_step) begin
         r_acc    <= w_next_acc;
         r_mcand  <= w_next_mcand;
         r_mplier <= w_next_mplier;
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

   // HI/LO capture and done pulse on the finish edge only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_finish) begin
            r_hi <= w_next_acc[2*WIDTH-1:WIDTH];
            r_lo <= w_next_acc[WIDTH-1:0];
         end
      end
   end

   // Writeback read mux; unused encodings read as zero
   always_comb begin
      w_rd_data = '0;
      if (sel_is_reg(bus.sel)) begin
         w_rd_data = (bus.sel == SEL_HI) ? r_hi : r_lo;
      end
   end

   assign bus.busy    = (r_state == ST_RUN);
   assign bus.done    = r_done;
   assign bus.hi      = r_hi;
   assign bus.lo      = r_lo;
   assign bus.rd_data = w_rd_data;
   assign o_dbg_state = r_state;

endmodule : multu_hilo

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo. Expected products and done cycles are
// queued when a start is driven and checked when done pulses.
module tb_multu_hilo;
   import multu_hilo_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   multu_state_e dbg_state;
   int           cyc;
   int           total;
   int           bad;
   int           done_cnt;

   logic [63:0] exp_q[$];
   int          exp_t[$];
   logic [63:0] mon_e;
   int          mon_t;

   multu_hilo_if #(.WIDTH(W)) bus ();

   multu_hilo #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // Clock and cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Expected RUN length for a given multiplier
   function automatic int lat(input logic [31:0] b);
`ifdef MULTU_EARLY_EXIT_EN
      int n;
      n = 1;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) n = i + 1;
      end
      return n;
`else
      return W;
`endif
   endfunction

   // Drive one start pulse; optionally queue its expected result
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit track);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      if (track) begin
         exp_q.push_back(64'(a) * 64'(b));
         exp_t.push_back(cyc + 1 + lat(b));
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Scoreboard: compare HI/LO and done timing whenever done pulses
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            mon_t = exp_t.pop_front();
            chk("hi", 64'(bus.hi), 64'(mon_e[63:32]));
            chk("lo", 64'(bus.lo), 64'(mon_e[31:0]));
            chk("done_cycle", 64'(cyc), 64'(mon_t));
            chk("busy_at_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   initial begin
      int n;
      int dc;
      logic [31:0] ra;
      logic [31:0] rb;
      total    = 0;
      bad      = 0;
      done_cnt = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.sel   = SEL_HI;

      // Reset state
      idle(2);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_rd", 64'(bus.rd_data), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      rst = 1'b0;
      bus.sel = SEL_NONE;

      // 1: 3*5, busy length, read LO
      issue(32'd3, 32'd5, 1'b1);
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t1_busy_cycles", 64'(n), 64'(lat(32'd5)));
      wait_done(100);
      bus.sel = SEL_LO;
      #1 chk("t1_rd_lo", 64'(bus.rd_data), 64'd15);
      bus.sel = SEL_HI;
      #1 chk("t1_rd_hi", 64'(bus.rd_data), 64'd0);

      // 2: all-ones operands
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_done(100);
      bus.sel = SEL_HI;
      #1 chk("t2_rd_hi", 64'(bus.rd_data), 64'h0000_0000_FFFF_FFFE);
      bus.sel = 2'b11;
      #1 chk("t2_rd_sel11", 64'(bus.rd_data), 64'd0);
      bus.sel = SEL_NONE;
      #1 chk("t2_rd_sel00", 64'(bus.rd_data), 64'd0);

      // 3: start while busy is ignored; HI/LO hold old result during RUN
      dc = done_cnt;
      issue(32'd7, 32'd6, 1'b1);
`ifndef MULTU_EARLY_EXIT_EN
      idle(8);
`endif
      chk("t3_hold_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      chk("t3_hold_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      chk("t3_busy", 64'(bus.busy), 64'd1);
      issue(32'd9, 32'd9, 1'b0);
      wait_done(100);
      idle(40);
      chk("t3_done_once", 64'(done_cnt - dc), 64'd1);
      chk("t3_lo", 64'(bus.lo), 64'd42);

      // 4: reset mid-run aborts with HI/LO cleared and no done
      issue(32'd3, 32'd5, 1'b1);
      wait_done(100);
      dc = done_cnt;
      issue(32'd100, 32'd100, 1'b0);
`ifdef MULTU_EARLY_EXIT_EN
      idle(2);
`else
      idle(10);
`endif
      chk("t4_busy_before", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("t4_busy", 64'(bus.busy), 64'd0);
      chk("t4_hi", 64'(bus.hi), 64'd0);
      chk("t4_lo", 64'(bus.lo), 64'd0);
      chk("t4_done", 64'(bus.done), 64'd0);
      idle(1);
      rst = 1'b0;
      idle(40);
      chk("t4_no_done", 64'(done_cnt - dc), 64'd0);

      // 5: start presented in the done cycle is accepted
      issue(32'd11, 32'd13, 1'b1);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (bus.done === 1'b1) break;
      end
      chk("t5_done_seen", 64'(bus.done), 64'd1);
      bus.start = 1'b1;
      bus.op_a  = 32'd2;
      bus.op_b  = 32'd2;
      exp_q.push_back(64'd4);
      exp_t.push_back(cyc + 1 + lat(32'd2));
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("t5_busy", 64'(bus.busy), 64'd1);
      wait_done(100);

      // 6: multiplier-length boundaries
      issue(32'h1234, 32'd1, 1'b1);
      wait_done(100);
      issue(32'hDEAD_BEEF, 32'h8000_0000, 1'b1);
      wait_done(100);
      issue(32'hCAFE_F00D, 32'd0, 1'b1);
      wait_done(100);
      issue(32'd0, 32'h0001_0000, 1'b1);
      wait_done(100);

      // Random operands
      for (int i = 0; i < 6; i++) begin
         ra = $urandom_range(32'hFFFF_FFFF, 0);
         rb = $urandom_range(32'hFFFF_FFFF, 0) >> $urandom_range(31, 0);
         issue(ra, rb, 1'b1);
         wait_done(100);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_multu_hilo
